// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer slice.
//   state_t        : sequencer states (ENTER_A, ENTER_B, WAIT_SUM, SHOW)
//   KEY_*          : keypad codes for the command keys (0-9 are digits,
//                    D-F are unused and ignored everywhere)
//   DISP_*         : display source selections
//   is_digit_code  : true for keypad codes 0-9
package operand_sequencer_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    WAIT_SUM = 2'd2,
    SHOW     = 2'd3
  } state_t;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_EQUAL = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [1:0] DISP_A      = 2'd0;
  localparam logic [1:0] DISP_B      = 2'd1;
  localparam logic [1:0] DISP_RESULT = 2'd2;

  function automatic logic is_digit_code(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/operand_sequencer_bcd_operand_reg.sv
// BCD operand shift register with digit counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero value and count (highest priority)
//   load     : value <= digit as the only digit, count <= 1
//   shift    : shift left one nibble, insert digit, count++ (ignored when full)
//   digit    : BCD digit to load/shift in
//   value    : N_DIGITS-digit BCD operand
//   count    : number of digits entered (0..N_DIGITS)
module bcd_operand_reg #(
  parameter int N_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    shift,
  input  logic [3:0]              digit,
  output logic [4*N_DIGITS-1:0]   value,
  output logic [2:0]              count
);

  localparam int OW = 4 * N_DIGITS;

  logic full;
  assign full = (count == 3'(N_DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= OW'(digit);
      count <= 3'd1;
    end else if (shift && !full) begin
      // Truncating cast drops the oldest nibble; it is always zero here
      // because the register is never shifted past N_DIGITS digits.
      value <= OW'({value, digit});
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Keypad-driven operand sequencer for a BCD adder.
//   clk, rst   : clock, asynchronous active-high reset
//   key_valid  : one-cycle keypad event strobe
//   key_code   : keypad code (0-9 digit, A plus, B equal, C clear)
//   add_done   : adder completion pulse, qualifies sum_in
//   sum_in     : BCD sum from the adder
//   operand_a  : BCD operand A to the adder
//   operand_b  : BCD operand B to the adder
//   add_start  : one-cycle adder request
//   result     : latched BCD sum
//   disp_sel   : display source (0 A, 1 B, 2 result)
//   error      : sticky adder timeout flag, cleared by CLEAR
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int N_DIGITS    = 3,
  parameter int SUM_TIMEOUT = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    add_done,
  input  logic [4*N_DIGITS+3:0]   sum_in,
  output logic [4*N_DIGITS-1:0]   operand_a,
  output logic [4*N_DIGITS-1:0]   operand_b,
  output logic                    add_start,
  output logic [4*N_DIGITS+3:0]   result,
  output logic [1:0]              disp_sel,
  output logic                    error
);

  localparam int TW = (SUM_TIMEOUT < 2) ? 1 : $clog2(SUM_TIMEOUT);

  state_t          state, state_nx;
  logic [2:0]      cnt_a, cnt_b;
  logic [TW-1:0]   timer;

  logic k_digit, k_plus, k_equal, k_clear;
  logic clr_a, clr_b, load_a, shift_a, shift_b;
  logic start_nx, latch_res, set_err, clr_err, timeout;

  assign k_digit = key_valid && is_digit_code(key_code);
  assign k_plus  = key_valid && (key_code == KEY_PLUS);
  assign k_equal = key_valid && (key_code == KEY_EQUAL);
  assign k_clear = key_valid && (key_code == KEY_CLEAR);

  // Timer holds the number of completed WAIT_SUM cycles, so the timeout
  // fires on the SUM_TIMEOUT-th cycle spent waiting.
  assign timeout = (state == WAIT_SUM) && !add_done &&
                   (timer == TW'(SUM_TIMEOUT - 1));

  bcd_operand_reg #(.N_DIGITS(N_DIGITS)) u_reg_a (
    .clk   (clk),
    .rst   (rst),
    .clear (clr_a),
    .load  (load_a),
    .shift (shift_a),
    .digit (key_code),
    .value (operand_a),
    .count (cnt_a)
  );

  bcd_operand_reg #(.N_DIGITS(N_DIGITS)) u_reg_b (
    .clk   (clk),
    .rst   (rst),
    .clear (clr_b),
    .load  (1'b0),
    .shift (shift_b),
    .digit (key_code),
    .value (operand_b),
    .count (cnt_b)
  );

  always_comb begin
    state_nx  = state;
    clr_a     = 1'b0;
    clr_b     = 1'b0;
    load_a    = 1'b0;
    shift_a   = 1'b0;
    shift_b   = 1'b0;
    start_nx  = 1'b0;
    latch_res = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;

    if (k_clear) begin
      // CLEAR outranks everything, including a coincident add_done.
      clr_a    = 1'b1;
      clr_b    = 1'b1;
      clr_err  = 1'b1;
      state_nx = ENTER_A;
    end else begin
      unique case (state)
        ENTER_A: begin
          if (k_digit) begin
            shift_a = 1'b1;
          end else if (k_plus && (cnt_a != '0)) begin
            state_nx = ENTER_B;
          end
        end
        ENTER_B: begin
          if (k_digit) begin
            shift_b = 1'b1;
          end else if (k_equal && (cnt_b != '0)) begin
            start_nx = 1'b1;
            state_nx = WAIT_SUM;
          end
        end
        WAIT_SUM: begin
          if (add_done) begin
            latch_res = 1'b1;
            state_nx  = SHOW;
          end else if (timeout) begin
            set_err  = 1'b1;
            clr_a    = 1'b1;
            clr_b    = 1'b1;
            state_nx = ENTER_A;
          end
        end
        SHOW: begin
          if (k_digit) begin
            load_a   = 1'b1;
            clr_b    = 1'b1;
            state_nx = ENTER_A;
          end
        end
        default: state_nx = ENTER_A;
      endcase
    end
  end

  always_comb begin
    disp_sel = DISP_A;
    unique case (state)
      ENTER_A:  disp_sel = DISP_A;
      ENTER_B:  disp_sel = DISP_B;
      WAIT_SUM: disp_sel = DISP_B;
      SHOW:     disp_sel = DISP_RESULT;
      default:  disp_sel = DISP_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ENTER_A;
      add_start <= 1'b0;
      result    <= '0;
      error     <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= state_nx;
      add_start <= start_nx;
      if (latch_res) begin
        result <= sum_in;
      end
      if (clr_err) begin
        error <= 1'b0;
      end else if (set_err) begin
        error <= 1'b1;
      end
      if ((state == WAIT_SUM) && (state_nx == WAIT_SUM)) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

  localparam int N  = 3;
  localparam int TO = 16;
  localparam int OW = 4 * N;
  localparam int RW = OW + 4;

  localparam logic [3:0] K_PLUS  = 4'hA;
  localparam logic [3:0] K_EQUAL = 4'hB;
  localparam logic [3:0] K_CLEAR = 4'hC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic          add_done = 1'b0;
  logic [RW-1:0] sum_in = '0;
  logic [OW-1:0] operand_a, operand_b;
  logic          add_start;
  logic [RW-1:0] result;
  logic [1:0]    disp_sel;
  logic          error;

  int vectors = 0;
  int miscompares = 0;
  int n_start = 0;

  // Reference model: mode 0 = entering A, 1 = entering B, 2 = waiting, 3 = showing
  int            m_mode = 0;
  int            qa[$];
  int            qb[$];
  logic [RW-1:0] m_result = '0;
  bit            m_err = 1'b0;
  bit            m_start = 1'b0;
  int            m_wait = 0;

  operand_sequencer #(.N_DIGITS(N), .SUM_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .add_done  (add_done),
    .sum_in    (sum_in),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .add_start (add_start),
    .result    (result),
    .disp_sel  (disp_sel),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] qval(input int q[$]);
    logic [OW-1:0] v = '0;
    foreach (q[i]) v = (v << 4) | OW'(q[i]);
    return v;
  endfunction

  function automatic logic [1:0] m_disp();
    return (m_mode == 0) ? 2'd0 : (m_mode == 3) ? 2'd2 : 2'd1;
  endfunction

  task automatic model_step(input bit kv, input logic [3:0] kc, input bit ad,
                            input logic [RW-1:0] s);
    m_start = 1'b0;
    if (kv && kc == K_CLEAR) begin
      qa.delete(); qb.delete(); m_err = 1'b0; m_mode = 0;
    end else begin
      case (m_mode)
        0: if (kv && kc <= 4'd9) begin
             if (qa.size() < N) qa.push_back(int'(kc));
           end else if (kv && kc == K_PLUS && qa.size() > 0) m_mode = 1;
        1: if (kv && kc <= 4'd9) begin
             if (qb.size() < N) qb.push_back(int'(kc));
           end else if (kv && kc == K_EQUAL && qb.size() > 0) begin
             m_mode = 2; m_start = 1'b1; m_wait = 0;
           end
        2: if (ad) begin
             m_result = s; m_mode = 3;
           end else begin
             m_wait++;
             if (m_wait == TO) begin
               m_err = 1'b1; qa.delete(); qb.delete(); m_mode = 0;
             end
           end
        3: if (kv && kc <= 4'd9) begin
             qa.delete(); qb.delete(); qa.push_back(int'(kc)); m_mode = 0;
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  // One clock: drive at negedge, advance the model at the edge, leave
  // outputs settled 1 time unit after the edge for checking.
  task automatic step(input bit kv, input logic [3:0] kc, input bit ad,
                      input logic [RW-1:0] s);
    @(negedge clk);
    key_valid = kv; key_code = kc; add_done = ad; sum_in = s;
    @(posedge clk);
    model_step(kv, kc, ad, s);
    #1;
    key_valid = 1'b0; add_done = 1'b0;
    if (add_start === 1'b1) n_start++;
  endtask

  task automatic press(input logic [3:0] kc);
    step(1'b1, kc, 1'b0, '0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; key_valid = 1'b0; add_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    qa.delete(); qb.delete();
    m_result = '0; m_err = 1'b0; m_mode = 0; m_start = 1'b0; m_wait = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (operand_a !== '0) begin miscompares++; $display("FAIL reset_opa got %h want 0", operand_a); end
    vectors++; if (operand_b !== '0) begin miscompares++; $display("FAIL reset_opb got %h want 0", operand_b); end
    vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result got %h want 0", result); end
    vectors++; if (add_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", add_start); end
    vectors++; if (disp_sel !== 2'd0) begin miscompares++; $display("FAIL reset_disp got %0d want 0", disp_sel); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", error); end
  endtask

  task automatic test_basic_add();
    press(K_CLEAR);
    press(4'd1); press(4'd2); press(K_PLUS); press(4'd3);
    n_start = 0;
    press(K_EQUAL);
    vectors++; if (add_start !== 1'b1) begin miscompares++; $display("FAIL add_start_pulse got %b want 1", add_start); end
    vectors++; if (operand_a !== 12'h012) begin miscompares++; $display("FAIL basic_opa got %h want 012", operand_a); end
    vectors++; if (operand_b !== 12'h003) begin miscompares++; $display("FAIL basic_opb got %h want 003", operand_b); end
    for (int i = 0; i < 3; i++) begin
      idle();
      vectors++; if (operand_a !== 12'h012 || operand_b !== 12'h003 || disp_sel !== 2'd1) begin
        miscompares++; $display("FAIL wait_stable a=%h b=%h disp=%0d want 012 003 1", operand_a, operand_b, disp_sel);
      end
    end
    vectors++; if (n_start != 1) begin miscompares++; $display("FAIL start_count got %0d want 1", n_start); end
    step(1'b0, 4'h0, 1'b1, 16'h0015);
    vectors++; if (result !== 16'h0015) begin miscompares++; $display("FAIL basic_result got %h want 0015", result); end
    vectors++; if (disp_sel !== 2'd2) begin miscompares++; $display("FAIL basic_disp got %0d want 2", disp_sel); end
  endtask

  task automatic test_show_digit();
    // Continues from SHOW left by test_basic_add.
    press(K_PLUS); press(K_EQUAL);
    vectors++; if (disp_sel !== 2'd2) begin miscompares++; $display("FAIL show_ops_ignored got %0d want 2", disp_sel); end
    press(4'd5);
    vectors++; if (operand_a !== 12'h005 || operand_b !== 12'h000 || disp_sel !== 2'd0) begin
      miscompares++; $display("FAIL show_digit a=%h b=%h disp=%0d want 005 000 0", operand_a, operand_b, disp_sel);
    end
    vectors++; if (result !== 16'h0015) begin miscompares++; $display("FAIL show_result_hold got %h want 0015", result); end
  endtask

  task automatic test_digit_limit();
    press(K_CLEAR);
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    vectors++; if (operand_a !== 12'h987) begin miscompares++; $display("FAIL digit_limit got %h want 987", operand_a); end
    press(K_PLUS); press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    vectors++; if (operand_b !== 12'h123 || operand_a !== 12'h987) begin
      miscompares++; $display("FAIL digit_limit_b a=%h b=%h want 987 123", operand_a, operand_b);
    end
  endtask

  task automatic test_empty_ops();
    press(K_CLEAR);
    n_start = 0;
    press(K_PLUS); press(K_EQUAL); press(4'hD); press(4'hE); press(4'hF); idle();
    vectors++; if (disp_sel !== 2'd0 || n_start != 0) begin
      miscompares++; $display("FAIL empty_ops disp=%0d starts=%0d want 0 0", disp_sel, n_start);
    end
    press(4'd4); press(K_PLUS); press(K_EQUAL); press(K_PLUS);
    vectors++; if (disp_sel !== 2'd1 || n_start != 0 || operand_a !== 12'h004) begin
      miscompares++; $display("FAIL empty_b disp=%0d starts=%0d a=%h want 1 0 004", disp_sel, n_start, operand_a);
    end
  endtask

  task automatic test_timeout();
    press(K_CLEAR);
    press(4'd4); press(K_PLUS); press(4'd5); press(K_EQUAL);
    for (int i = 0; i < TO - 1; i++) idle();
    vectors++; if (error !== 1'b0 || disp_sel !== 2'd1) begin
      miscompares++; $display("FAIL timeout_early err=%b disp=%0d want 0 1", error, disp_sel);
    end
    idle();
    vectors++; if (error !== 1'b1 || disp_sel !== 2'd0 || operand_a !== '0 || operand_b !== '0) begin
      miscompares++; $display("FAIL timeout err=%b disp=%0d a=%h b=%h want 1 0 0 0", error, disp_sel, operand_a, operand_b);
    end
    step(1'b0, 4'h0, 1'b1, 16'h0333);
    vectors++; if (result !== m_result || error !== 1'b1) begin
      miscompares++; $display("FAIL late_done result=%h err=%b want %h 1", result, error, m_result);
    end
    press(K_CLEAR);
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL timeout_clear got %b want 0", error); end
  endtask

  task automatic test_clear_vs_done();
    press(K_CLEAR);
    press(4'd2); press(K_PLUS); press(4'd2); press(K_EQUAL);
    step(1'b0, 4'h0, 1'b1, 16'h0004);
    press(K_CLEAR);
    press(4'd1); press(K_PLUS); press(4'd1); press(K_EQUAL);
    step(1'b1, K_CLEAR, 1'b1, 16'h0099);
    vectors++; if (disp_sel !== 2'd0 || result !== 16'h0004) begin
      miscompares++; $display("FAIL clear_vs_done disp=%0d result=%h want 0 0004", disp_sel, result);
    end
  endtask

  task automatic test_reset_in_wait();
    press(K_CLEAR);
    press(4'd3); press(K_PLUS); press(4'd3); press(K_EQUAL);
    do_reset();
    step(1'b0, 4'h0, 1'b1, 16'h0077);
    vectors++; if (result !== 16'h0000 || disp_sel !== 2'd0) begin
      miscompares++; $display("FAIL reset_in_wait result=%h disp=%0d want 0000 0", result, disp_sel);
    end
  endtask

  task automatic test_random();
    bit kv, ad;
    logic [3:0] kc;
    logic [RW-1:0] s;
    int r;
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      kv = (r < 70);
      if (r < 40)      kc = 4'($urandom_range(0, 9));
      else if (r < 50) kc = K_PLUS;
      else if (r < 60) kc = K_EQUAL;
      else if (r < 63) kc = K_CLEAR;
      else             kc = 4'($urandom_range(13, 15));
      ad = ($urandom_range(0, 3) == 0);
      s  = RW'($urandom);
      step(kv, kc, ad, s);
      vectors++; if (operand_a !== qval(qa)) begin miscompares++; $display("FAIL rnd_opa cyc %0d got %h want %h", i, operand_a, qval(qa)); end
      vectors++; if (operand_b !== qval(qb)) begin miscompares++; $display("FAIL rnd_opb cyc %0d got %h want %h", i, operand_b, qval(qb)); end
      vectors++; if (result !== m_result) begin miscompares++; $display("FAIL rnd_result cyc %0d got %h want %h", i, result, m_result); end
      vectors++; if (add_start !== m_start) begin miscompares++; $display("FAIL rnd_start cyc %0d got %b want %b", i, add_start, m_start); end
      vectors++; if (disp_sel !== m_disp()) begin miscompares++; $display("FAIL rnd_disp cyc %0d got %0d want %0d", i, disp_sel, m_disp()); end
      vectors++; if (error !== m_err) begin miscompares++; $display("FAIL rnd_error cyc %0d got %b want %b", i, error, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_show_digit();
    test_digit_limit();
    test_empty_ops();
    test_timeout();
    test_clear_vs_done();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
